// File: rtl/fft_out_reorder_pkg.sv
// Shared constants, types and index helper for the 32-point SDF FFT output stage.
// The bitrev helper is also intended for the FFT stage benches.
package fft_out_reorder_pkg;

  localparam int N     = 32;
  localparam int LOG2N = 5;
  localparam int DW    = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } rd_state_e;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } sample_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) begin
      r[b] = a[LOG2N-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// Streaming bus of the reorder buffer: bit-reversed input side and natural-order output side.
interface fft_out_reorder_if;
  import fft_out_reorder_pkg::*;

  logic                 valid_i;
  logic signed [DW-1:0] data_in_r;
  logic signed [DW-1:0] data_in_i;
  logic                 valid_o;
  logic                 frame_start_o;
  logic signed [DW-1:0] data_out_r;
  logic signed [DW-1:0] data_out_i;
  logic                 err_o;

  modport master (
    output valid_i, data_in_r, data_in_i,
    input  valid_o, frame_start_o, data_out_r, data_out_i, err_o
  );

  modport slave (
    input  valid_i, data_in_r, data_in_i,
    output valid_o, frame_start_o, data_out_r, data_out_i, err_o
  );

endinterface

// File: rtl/fft_reorder_bank.sv
// Ping-pong storage: two N-entry banks of complex samples, one write port and one
// combinational read port. Contents are deliberately not reset.
module fft_reorder_bank
  import fft_out_reorder_pkg::*;
(
  input  logic             clk,
  input  logic             i_we,
  input  logic             i_wbank,
  input  logic [LOG2N-1:0] i_waddr,
  input  sample_t          i_wdata,
  input  logic             i_rbank,
  input  logic [LOG2N-1:0] i_raddr,
  output sample_t          o_rdata
);

  sample_t r_mem [2][N];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_wbank][i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_rbank][i_raddr];

endmodule

// File: rtl/fft_out_reorder.sv
// Output reorder buffer: stores bit-reversed frames into alternating banks and
// replays each completed frame in natural order as one contiguous N-cycle burst.
module fft_out_reorder
  import fft_out_reorder_pkg::*;
(
  input  logic clk,
  input  logic rst,
  fft_out_reorder_if.slave bus
);

  logic [LOG2N-1:0]     r_wcnt;
  logic                 r_wbank;
  logic [LOG2N-1:0]     r_rcnt;
  logic                 r_rbank;
  logic [1:0]           r_full;
  rd_state_e            r_state;
  logic                 r_err;
  logic                 r_valid;
  logic                 r_fstart;
  logic signed [DW-1:0] r_outR;
  logic signed [DW-1:0] r_outI;

  logic                 w_wrLast;
  logic                 w_rdLast;
  logic [1:0]           w_fullSet;
  logic [1:0]           w_fullClr;
  logic [LOG2N-1:0]     w_raddr;
  sample_t              w_wdata;
  sample_t              w_rdata;

  assign w_wrLast  = bus.valid_i && (r_wcnt == LOG2N'(N-1));
  assign w_rdLast  = (r_state == ST_READ) && (r_rcnt == LOG2N'(N-2));
  assign w_fullSet = w_wrLast ? (r_wbank ? 2'b10 : 2'b01) : 2'b00;
  assign w_fullClr = w_rdLast ? (r_rbank ? 2'b10 : 2'b01) : 2'b00;

  // Address 0 is presented whenever the next edge may start a burst: in IDLE,
  // and on the wrap edge where a back-to-back burst of the other bank can begin.
  assign w_raddr = ((r_state == ST_READ) && (r_rcnt != LOG2N'(N-1)))
                   ? r_rcnt + 1'b1 : '0;

  assign w_wdata.re = bus.data_in_r;
  assign w_wdata.im = bus.data_in_i;

  fft_reorder_bank u_bank (
    .clk     (clk),
    .i_we    (bus.valid_i),
    .i_wbank (r_wbank),
    .i_waddr (bitrev(r_wcnt)),
    .i_wdata (w_wdata),
    .i_rbank (r_rbank),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wcnt  <= '0;
      r_wbank <= 1'b0;
      r_err   <= 1'b0;
    end else if (bus.valid_i) begin
      r_wcnt <= r_wcnt + 1'b1;
      if (w_wrLast) begin
        r_wbank <= ~r_wbank;
      end
      if (r_full[r_wbank]) begin
        r_err <= 1'b1;
      end
    end
  end

  // Set wins over clear if both ever hit the same bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= 2'b00;
    end else begin
      r_full <= (r_full & ~w_fullClr) | w_fullSet;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_rcnt   <= '0;
      r_rbank  <= 1'b0;
      r_valid  <= 1'b0;
      r_fstart <= 1'b0;
      r_outR   <= '0;
      r_outI   <= '0;
    end else begin
      r_fstart <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_full[r_rbank]) begin
            r_state  <= ST_READ;
            r_rcnt   <= '0;
            r_valid  <= 1'b1;
            r_fstart <= 1'b1;
            r_outR   <= w_rdata.re;
            r_outI   <= w_rdata.im;
          end else begin
            r_valid <= 1'b0;
          end
        end
        ST_READ: begin
          if (r_rcnt == LOG2N'(N-1)) begin
            if (r_full[r_rbank]) begin
              r_rcnt   <= '0;
              r_valid  <= 1'b1;
              r_fstart <= 1'b1;
              r_outR   <= w_rdata.re;
              r_outI   <= w_rdata.im;
            end else begin
              r_state <= ST_IDLE;
              r_valid <= 1'b0;
            end
          end else begin
            r_rcnt  <= r_rcnt + 1'b1;
            r_valid <= 1'b1;
            r_outR  <= w_rdata.re;
            r_outI  <= w_rdata.im;
            if (w_rdLast) begin
              r_rbank <= ~r_rbank;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.valid_o       = r_valid;
  assign bus.frame_start_o = r_fstart;
  assign bus.data_out_r    = r_outR;
  assign bus.data_out_i    = r_outI;
  assign bus.err_o         = r_err;

endmodule

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
- Output reorder buffer placed directly after the last radix-2 stage of the 32-point SDF FFT pipeline.
- Consumes the last stage's streaming output, which arrives in bit-reversed index order: valid-qualified, 16-bit signed real/imag, no backpressure.
- Emits each 32-point frame in natural order (X[0]..X[31]) as one contiguous 32-cycle burst, using a ping-pong pair of 32-entry banks.

Parameters:
- N, 32, points per frame (power of two).
- LOG2N, 5, address width, log2(N).
- DW, 16, sample width per component (real and imaginary).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- valid_i  input  1  data_in_r/data_in_i hold a sample this cycle.
- data_in_r  input  DW  real part, signed, bit-reversed order.
- data_in_i  input  DW  imaginary part, signed, bit-reversed order.
- valid_o  output  1  data_out_r/data_out_i hold a sample this cycle.
- frame_start_o  output  1  high together with X[0] of each output burst.
- data_out_r  output  DW  real part, signed, natural order.
- data_out_i  output  DW  imaginary part, signed, natural order.
- err_o  output  1  sticky overflow flag.

Behaviour:
- Reset: one clock; asynchronous, active-low reset `rst`. While rst=0, all of the following clear immediately:
  - outputs valid_o, frame_start_o, data_out_r, data_out_i, err_o go to 0;
  - wcnt, wbank, rcnt, rbank, reading and full[1:0] go to 0;
  - bank contents need not be cleared.
- Reset mid-frame discards any partial write frame and any burst in progress. The first valid_i after reset is sample 0 of a new frame.
- Write side:
  - On each edge with valid_i=1: mem[wbank][bitrev(wcnt)] <= {data_in_r, data_in_i}, then wcnt++.
  - Gaps in valid_i are allowed; wcnt holds during a gap.
  - When wcnt=N-1 is written: full[wbank] <= 1, wbank toggles, wcnt wraps to 0.
- Overflow: a write into a bank whose full bit is set sets err_o (sticky until reset). The write still happens and the data is corrupt. This cannot occur at ≤1 sample/cycle, so it is a defensive flag only.
- Read FSM, states IDLE and READ:
  - IDLE: if full[rbank]=1, then on that edge go to READ with rcnt=0. Register data_out <= mem[rbank][0], valid_o <= 1, frame_start_o <= 1.
  - READ: each edge outputs mem[rbank][rcnt+1] with valid_o=1 and frame_start_o=0.
  - After issuing address N-1: clear full[rbank], toggle rbank. Then on the next edge either start the other bank immediately if it is full (back-to-back bursts, no idle cycle) or return to IDLE with valid_o <= 0.
  - Output data holds its last value when valid_o=0.
- Latency: if the frame's last write happens at edge E, X[0] is valid after edge E+1 and X[31] after edge E+32.
- Same-cycle events:
  - The write of a frame's last sample and the read start on the next edge are independent.
  - full-set and full-clear on different banks in the same cycle both take effect.
  - full-set and full-clear on the same bank cannot coincide in legal operation. If it happens, set wins and err_o is already raised.
- Arithmetic: none. Data passes through bit-exact; signedness is preserved.

Decomposition:
- Shared package: N, LOG2N, DW constants; bitrev function (LOG2N-bit reversal), also usable by the FFT stage benches.
- One natural sub-module: fft_reorder_bank, a dual-bank 2×N×(2·DW) register array with one write port and one read port.
- The top level holds the counters, full flags, read FSM and output registers.

Test Plan:
- Single frame: input sample at position k carries value r=bitrev(k), i=-bitrev(k), 32 cycles gapless -> one 32-cycle burst with data_out_r=0..31 and data_out_i=0..-31. frame_start_o high only with 0. Timing is exact: X[0] at E+1.
- Back-to-back frames: 4 frames gapless, frame f value = 100·f + natural index -> 128 consecutive valid_o cycles in order, frame_start_o every 32 cycles, err_o=0.
- Gapped input: valid_i toggling 1,0,1,0 for one frame -> output is still one contiguous 32-cycle natural-order burst starting 1 edge after the 32nd write.
- Reset mid-operation: rst low after 17 input samples of frame 1 while frame 0 is bursting -> all outputs 0 immediately. A full clean frame then reorders correctly with no remnants.
- Boundary values: samples -32768/32767 in real and imag -> bit-exact output, sign preserved.
- Overflow forcing: hold the read FSM in IDLE via a bench force while 3 frames are written -> err_o rises on the first write of frame 2 and stays 1 until rst.
